// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: credit-limited issue, read tracking pipe, return FIFO.
// Optional FETCH_BYPASS_EN presents returning data to decode in the return cycle when the FIFO is empty.
module fetch_unit #(
   parameter int DEPTH   = 4,
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc_addr,
   output logic        pc_incr,
   input  logic        redirect,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic               r_started;
   logic [MEM_LAT-1:0] r_pv;
   logic [15:0]        r_pa [MEM_LAT];
   logic [15:0]        r_fd [DEPTH];
   logic [15:0]        r_fa [DEPTH];
   logic [AW-1:0]      r_wp;
   logic [AW-1:0]      r_rp;
   logic [CW-1:0]      r_occ;

   int                 w_inflight;
   logic               w_issue;
   logic               w_ret;
   logic [15:0]        w_ret_addr;
   logic               w_empty;
   logic               w_byp;
   logic               w_push;
   logic               w_pop;

   always_comb begin
      w_inflight = 0;
      for (int i = 0; i < MEM_LAT; i++) begin
         w_inflight = w_inflight + int'(r_pv[i]);
      end
   end

   // Credit: buffered plus in-flight reads never exceed FIFO depth, so a return always has room.
   assign w_issue    = r_started && !redirect && ((int'(r_occ) + w_inflight) < DEPTH);
   assign mem_rd     = w_issue;
   assign pc_incr    = w_issue;
   assign mem_addr   = w_issue ? pc_addr : 16'h0000;

   assign w_ret      = r_pv[MEM_LAT-1];
   assign w_ret_addr = r_pa[MEM_LAT-1];
   assign w_empty    = (r_occ == '0);

`ifdef FETCH_BYPASS_EN
   assign w_byp      = w_ret && w_empty && !redirect;
`else
   assign w_byp      = 1'b0;
`endif

   assign instr_valid = !w_empty || w_byp;
   assign w_pop       = !w_empty && instr_ready;
   // A bypassed word taken by decode this cycle is not also written into the FIFO.
   assign w_push      = w_ret && !redirect && !(w_byp && instr_ready);

   always_comb begin
      instr    = 16'h0000;
      instr_pc = 16'h0000;
      if (!w_empty) begin
         instr    = r_fd[r_rp];
         instr_pc = r_fa[r_rp];
      end else if (w_byp) begin
         instr    = mem_rdata;
         instr_pc = w_ret_addr;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_started <= 1'b0;
         r_pv      <= '0;
         r_wp      <= '0;
         r_rp      <= '0;
         r_occ     <= '0;
         for (int i = 0; i < MEM_LAT; i++) begin
            r_pa[i] <= 16'h0000;
         end
         for (int i = 0; i < DEPTH; i++) begin
            r_fd[i] <= 16'h0000;
            r_fa[i] <= 16'h0000;
         end
      end else begin
         r_started <= 1'b1;
         for (int i = MEM_LAT - 1; i > 0; i--) begin
            r_pv[i] <= r_pv[i-1] && !redirect;
            r_pa[i] <= r_pa[i-1];
         end
         r_pv[0] <= w_issue;
         r_pa[0] <= pc_addr;

         // Redirect kills everything buffered; the decode-side pop this cycle already happened.
         if (redirect) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
         end else begin
            if (w_push) begin
               r_fd[r_wp] <= mem_rdata;
               r_fa[r_wp] <= w_ret_addr;
               r_wp       <= r_wp + AW'(1);
            end
            if (w_pop) begin
               r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_occ <= r_occ + CW'(1);
               2'b01:   r_occ <= r_occ - CW'(1);
               default: r_occ <= r_occ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: vector table, scoreboard, directed corner sequences.
`timescale 1ns/1ps
module tb_fetch_unit;

   localparam int DEPTH   = 4;
   localparam int MEM_LAT = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc_addr;
   logic        pc_incr;
   logic        redirect = 1'b0;
   logic [15:0] redirect_target = 16'h0000;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_addr     (pc_addr),
      .pc_incr     (pc_incr),
      .redirect    (redirect),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // PC register behaviour and a fixed-latency instruction memory
   logic [15:0] pc_q;
   always @(posedge clk or posedge reset) begin
      if (reset)         pc_q <= 16'h0000;
      else if (redirect) pc_q <= redirect_target;
      else if (pc_incr)  pc_q <= pc_q + 16'd2;
   end
   assign pc_addr = pc_q;

   logic        mv [MEM_LAT];
   logic [15:0] ma [MEM_LAT];
   always @(posedge clk) begin
      mv[0] <= mem_rd;
      ma[0] <= mem_addr;
      for (int i = 1; i < MEM_LAT; i++) begin
         mv[i] <= mv[i-1];
         ma[i] <= ma[i-1];
      end
   end
   assign mem_rdata = mv[MEM_LAT-1] ? mem_word(ma[MEM_LAT-1]) : 16'hDEAD;

   // Scoreboard: expectation queued at issue, compared at each decode handshake
   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] data;
   } exp_t;
   exp_t        sb [$];
   exp_t        sb_e;
   logic [15:0] got_pc [$];

   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow actual_pc=%h required=none", instr_pc);
            end else begin
               sb_e = sb.pop_front();
               check("sb_pc", instr_pc, sb_e.pc);
               check("sb_instr", instr, sb_e.data);
            end
            got_pc.push_back(instr_pc);
         end
         if (redirect) sb.delete();
         if (mem_rd) sb.push_back('{mem_addr, mem_word(mem_addr)});
      end
   end

   typedef struct {
      logic        ready;
      logic        rd;
      logic [15:0] addr;
      logic        incr;
      logic        valid;
      logic [15:0] ipc;
   } vec_t;
   vec_t tbl [12];

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      redirect = 1'b0;
      instr_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ready, mem_rd, mem_addr, pc_incr, instr_valid, instr_pc per cycle from reset release
      tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000};
      tbl[2]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0000};
      tbl[3]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 1'b1, 16'h0000};
      tbl[4]  = '{1'b0, 1'b1, 16'h0006, 1'b1, 1'b1, 16'h0000};
      tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
      tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
      tbl[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
      tbl[8]  = '{1'b1, 1'b1, 16'h0008, 1'b1, 1'b1, 16'h0002};
      tbl[9]  = '{1'b1, 1'b1, 16'h000A, 1'b1, 1'b1, 16'h0004};
      tbl[10] = '{1'b1, 1'b1, 16'h000C, 1'b1, 1'b1, 16'h0006};
      tbl[11] = '{1'b1, 1'b1, 16'h000E, 1'b1, 1'b1, 16'h0008};

      #1;
      check("reset_mem_rd", 16'(mem_rd), 16'h0);
      check("reset_instr_valid", 16'(instr_valid), 16'h0);
      check("reset_instr_pc", instr_pc, 16'h0);

      do_reset();
      for (int k = 0; k < 12; k++) begin
         instr_ready = tbl[k].ready;
         @(negedge clk);
         check($sformatf("v%0d_mem_rd", k), 16'(mem_rd), 16'(tbl[k].rd));
         check($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].addr);
         check($sformatf("v%0d_pc_incr", k), 16'(pc_incr), 16'(tbl[k].incr));
         check($sformatf("v%0d_valid", k), 16'(instr_valid), 16'(tbl[k].valid));
         check($sformatf("v%0d_instr_pc", k), instr_pc, tbl[k].ipc);
         check($sformatf("v%0d_instr", k), instr, tbl[k].valid ? mem_word(tbl[k].ipc) : 16'h0);
         @(posedge clk);
         #1;
      end

      // Redirect with two buffered and one in flight
      do_reset();
      repeat (4) @(posedge clk);
      #1;
      redirect_target = 16'h0100;
      redirect = 1'b1;
      @(negedge clk);
      check("redir_mem_rd", 16'(mem_rd), 16'h0);
      check("redir_pc_incr", 16'(pc_incr), 16'h0);
      check("redir_valid_before", 16'(instr_valid), 16'h1);
      @(posedge clk);
      #1 redirect = 1'b0;
      got_pc.delete();
      @(negedge clk);
      check("redir_valid_after", 16'(instr_valid), 16'h0);
      check("redir_issue_rd", 16'(mem_rd), 16'h1);
      check("redir_issue_addr", mem_addr, 16'h0100);
      @(posedge clk);
      #1 instr_ready = 1'b1;
      for (int n = 0; n < 10 && got_pc.size() == 0; n++) @(posedge clk);
      if (got_pc.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL redir_first_pc actual=none required=0100");
      end else begin
         check("redir_first_pc", got_pc[0], 16'h0100);
      end

      // Push and pop together at occupancy 3
      do_reset();
      got_pc.delete();
      repeat (5) @(posedge clk);
      #1 instr_ready = 1'b1;
      @(negedge clk);
      check("pp_head_pc", instr_pc, 16'h0000);
      check("pp_no_issue", 16'(mem_rd), 16'h0);
      @(posedge clk);
      #1 instr_ready = 1'b0;
      @(negedge clk);
      check("pp_head_next", instr_pc, 16'h0002);
      check("pp_issue_occ3", 16'(mem_rd), 16'h1);
      check("pp_issue_addr", mem_addr, 16'h0008);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("pp_full_credit", 16'(mem_rd), 16'h0);
      @(posedge clk);
      #1 instr_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("pp_count", 16'(got_pc.size() >= 5), 16'h1);
      for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
         check($sformatf("pp_order%0d", i), got_pc[i], 16'(2 * i));
      end

      // Asynchronous reset mid-stream with three buffered
      do_reset();
      repeat (5) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("areset_valid", 16'(instr_valid), 16'h0);
      check("areset_instr", instr, 16'h0);
      check("areset_instr_pc", instr_pc, 16'h0);
      check("areset_mem_rd", 16'(mem_rd), 16'h0);
      check("areset_mem_addr", mem_addr, 16'h0);
      check("areset_pc_incr", 16'(pc_incr), 16'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("restart_rd", 16'(mem_rd), 16'h1);
      check("restart_addr", mem_addr, 16'h0000);

      // Address wrap and FIFO pointer wrap under sustained streaming
      do_reset();
      instr_ready = 1'b1;
      redirect_target = 16'hFFFC;
      redirect = 1'b1;
      @(posedge clk);
      #1 redirect = 1'b0;
      got_pc.delete();
      repeat (20) @(posedge clk);
      #1;
      check("wrap_count", 16'(got_pc.size() >= 16), 16'h1);
      if (got_pc.size() >= 3) begin
         check("wrap_pc0", got_pc[0], 16'hFFFC);
         check("wrap_pc1", got_pc[1], 16'hFFFE);
         check("wrap_pc2", got_pc[2], 16'h0000);
      end
      begin
         int bad;
         bad = 0;
         for (int i = 1; i < got_pc.size(); i++) begin
            if (got_pc[i] != got_pc[i-1] + 16'd2) bad++;
         end
         check("wrap_stride", 16'(bad), 16'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
